// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch slice: widths, opcode constants,
// fetch FSM state encoding and a PC alignment helper.
package fetch_pkg;

    localparam int INSTR_W = 32;
    localparam int XLEN    = 32;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;

    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
        return {pc[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_if.sv
// Bus interfaces of the fetch stage: instruction-memory request/response and
// the decode-facing valid/ready channel. master = the fetch stage side.
interface imem_if;
    import fetch_pkg::*;

    logic               req_valid;
    logic [XLEN-1:0]    req_addr;
    logic               req_ready;
    logic               rsp_valid;
    logic [INSTR_W-1:0] rsp_data;

    modport master (output req_valid, req_addr, input req_ready, rsp_valid, rsp_data);
    modport slave  (input req_valid, req_addr, output req_ready, rsp_valid, rsp_data);
endinterface

interface dec_if;
    import fetch_pkg::*;

    logic               valid;
    logic               ready;
    logic [INSTR_W-1:0] instr;
    logic [XLEN-1:0]    pc;
    logic [6:0]         opcode;
    logic [2:0]         funct3;
    logic [6:0]         funct7;

    modport master (output valid, instr, pc, opcode, funct3, funct7, input ready);
    modport slave  (input valid, instr, pc, opcode, funct3, funct7, output ready);
endinterface

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush and occupancy count; DEPTH must be a power of 2 (>=2)
// so the pointers wrap naturally.
module fetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             empty,
    output logic [CW-1:0]    count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty && !flush;
    // A pop frees the slot, so a push at full is accepted in the same cycle.
    assign do_push = push && (!full || do_pop) && !flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    assign rdata = mem[rd_ptr];

endmodule

// File: rtl/instr_fetch_stage.sv
// Fetch stage: owns the PC, issues in-order imem requests under a credit limit,
// buffers responses and presents them to decode. Optional `FETCH_PERF_CNT_EN adds perf_fetch_cnt.
module instr_fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
    parameter int              FIFO_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    imem_if.master          imem,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    dec_if.master           dec
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]     perf_fetch_cnt
`endif
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int EW = INSTR_W + XLEN;

    fetch_state_t       state;
    fetch_state_t       state_nxt;
    logic [XLEN-1:0]    pc;
    logic [XLEN-1:0]    rsp_pc;
    logic [CW-1:0]      outstanding;
    logic [CW-1:0]      outstanding_nxt;
    logic [CW-1:0]      fifo_count;
    logic               fifo_empty;
    logic [EW-1:0]      head;
    logic               req_valid;
    logic               req_fire;
    logic               push;
    logic               pop;
    logic [INSTR_W-1:0] instr;

    always_comb begin
        state_nxt = state;
        req_valid = 1'b0;
        push      = 1'b0;
        if (state == RUN) begin
            // Credit: in-flight plus buffered words may never exceed the buffer size.
            req_valid = !redirect_valid &&
                        ((int'(outstanding) + int'(fifo_count)) < FIFO_DEPTH);
            push      = imem.rsp_valid && !redirect_valid;
        end
        req_fire        = req_valid && imem.req_ready;
        outstanding_nxt = outstanding + CW'(req_fire) - CW'(imem.rsp_valid);
        unique case (state)
            BOOT:    state_nxt = RUN;
            RUN:     if (redirect_valid && (outstanding_nxt != '0)) state_nxt = DRAIN;
            DRAIN:   if (!redirect_valid && (outstanding_nxt == '0)) state_nxt = RUN;
            default: state_nxt = BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= BOOT;
            pc          <= RESET_PC;
            rsp_pc      <= RESET_PC;
            outstanding <= '0;
        end else begin
            state       <= state_nxt;
            outstanding <= outstanding_nxt;
            // rsp_pc tags the next accepted response; responses return in request order.
            if (redirect_valid) begin
                pc     <= align_pc(redirect_pc);
                rsp_pc <= align_pc(redirect_pc);
            end else begin
                if (req_fire) pc     <= pc + 32'd4;
                if (push)     rsp_pc <= rsp_pc + 32'd4;
            end
        end
    end

    assign imem.req_valid = req_valid;
    assign imem.req_addr  = pc;

    assign pop = dec.valid && dec.ready && !redirect_valid;

    fetch_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (redirect_valid),
        .push  (push),
        .wdata ({rsp_pc, imem.rsp_data}),
        .pop   (pop),
        .rdata (head),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign instr      = fifo_empty ? '0 : head[INSTR_W-1:0];
    assign dec.valid  = !fifo_empty;
    assign dec.instr  = instr;
    assign dec.pc     = fifo_empty ? '0 : head[INSTR_W +: XLEN];
    assign dec.opcode = instr[6:0];
    assign dec.funct3 = instr[14:12];
    assign dec.funct7 = instr[31:25];

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetch_cnt <= '0;
        end else if (dec.valid && dec.ready) begin
            perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
        end
    end
`endif

endmodule
